// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: MIDI note strobes -> per-voice gate/trig/note/velocity.
// Oldest-first allocation with stealing; queued events are resolved by a one-voice-per-cycle scan.
//
// state  | meaning
// IDLE   | waiting for a queued event, pops it into the event register
// SCAN   | examines voice idx, tracks match / oldest free / oldest active
// COMMIT | applies the event to the chosen voice
// REGATE | raises the gate again one cycle after a retrigger or steal
module voice_alloc #(
  parameter int VOICES     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                note_on,
  input  logic                note_off,
  input  logic                panic,
  input  logic [6:0]          note,
  input  logic [6:0]          velocity,
  output logic [VOICES-1:0]   gate,
  output logic [VOICES-1:0]   trig,
  output logic [7*VOICES-1:0] voice_note,
  output logic [7*VOICES-1:0] voice_vel,
  output logic                busy,
  output logic                ovf
);
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, REGATE} state_t;
  state_t state, state_nxt;

  logic [14:0]   fifo_mem [FIFO_DEPTH];
  logic [14:0]   ev_in;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          fifo_empty, fifo_full, strobe, push, drop, pop;

  logic          ev_on;
  logic [6:0]    ev_note, ev_vel;
  logic [IW-1:0] idx, tgt, sel;
  logic          sel_regate;
  logic          match_vld, free_vld, act_vld;
  logic [IW-1:0] match_idx, free_idx, act_idx, free_rank, act_rank;
  logic [IW-1:0] rank [VOICES];
  logic          cur_gate;
  logic [6:0]    cur_note;
  logic [IW-1:0] cur_rank;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign strobe     = note_on | note_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SCAN;
      SCAN:    if (idx == LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = (ev_on && sel_regate) ? REGATE : IDLE;
      REGATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (panic) state_nxt = IDLE;
  end

  always_comb begin
    push = strobe & ~panic & ~fifo_full;
    drop = strobe & ~panic & fifo_full;
    pop  = (state == IDLE) & ~fifo_empty & ~panic;
    if (note_on && velocity != 7'd0) ev_in = {1'b1, note, velocity};
    else                             ev_in = {1'b0, note, 7'd0};
    count_nxt = panic ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // match first (retrigger), then oldest free voice, otherwise steal the oldest active one
    sel        = act_idx;
    sel_regate = 1'b1;
    if (match_vld) begin
      sel = match_idx;
    end else if (free_vld) begin
      sel        = free_idx;
      sel_regate = 1'b0;
    end
    cur_gate = 1'b0;
    cur_note = '0;
    cur_rank = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (IW'(i) == idx) begin
        cur_gate = gate[i];
        cur_note = voice_note[7*i +: 7];
        cur_rank = rank[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ev_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate       <= '0;
      trig       <= '0;
      voice_note <= '0;
      voice_vel  <= '0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ev_on      <= 1'b0;
      ev_note    <= '0;
      ev_vel     <= '0;
      idx        <= '0;
      tgt        <= '0;
      match_vld  <= 1'b0;
      free_vld   <= 1'b0;
      act_vld    <= 1'b0;
      match_idx  <= '0;
      free_idx   <= '0;
      act_idx    <= '0;
      free_rank  <= '0;
      act_rank   <= '0;
      for (int i = 0; i < VOICES; i++) rank[i] <= IW'(VOICES - 1 - i);
    end else begin
      trig  <= '0;
      count <= count_nxt;
      busy  <= (state_nxt != IDLE) || (count_nxt != '0);
      if (panic) begin
        gate   <= '0;
        ovf    <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (drop) ovf <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr                   <= rd_ptr + 1'b1;
          {ev_on, ev_note, ev_vel} <= fifo_mem[rd_ptr];
          idx                      <= '0;
          match_vld                <= 1'b0;
          free_vld                 <= 1'b0;
          act_vld                  <= 1'b0;
        end
        case (state)
          SCAN: begin
            if (cur_gate && cur_note == ev_note) begin
              match_vld <= 1'b1;
              match_idx <= idx;
            end
            if (!cur_gate && (!free_vld || cur_rank > free_rank)) begin
              free_vld  <= 1'b1;
              free_idx  <= idx;
              free_rank <= cur_rank;
            end
            if (cur_gate && (!act_vld || cur_rank > act_rank)) begin
              act_vld  <= 1'b1;
              act_idx  <= idx;
              act_rank <= cur_rank;
            end
            idx <= idx + 1'b1;
          end
          COMMIT: begin
            if (ev_on) begin
              tgt <= sel;
              for (int i = 0; i < VOICES; i++) begin
                if (IW'(i) == sel) begin
                  voice_note[7*i +: 7] <= ev_note;
                  voice_vel[7*i +: 7]  <= ev_vel;
                  trig[i]              <= 1'b1;
                  gate[i]              <= ~sel_regate;
                  rank[i]              <= '0;
                end else if (rank[i] < rank[sel]) begin
                  rank[i] <= rank[i] + 1'b1;
                end
              end
            end else if (match_vld) begin
              for (int i = 0; i < VOICES; i++)
                if (IW'(i) == match_idx) gate[i] <= 1'b0;
            end
          end
          REGATE: begin
            for (int i = 0; i < VOICES; i++)
              if (IW'(i) == tgt) gate[i] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
